// File: rtl/subtractor_hcs_pipe_if.sv
// subtractor_hcs_pipe_if: valid/ready operand and result streams of the pipelined subtractor
interface subtractor_hcs_pipe_if #(
    parameter int WIDTH = 16
);
    logic             s_valid;
    logic             s_ready;
    logic [WIDTH-1:0] s_a;
    logic [WIDTH-1:0] s_b;
    logic             s_bi;
    logic             m_valid;
    logic             m_ready;
    logic [WIDTH-1:0] m_d;
    logic             m_bo;
    logic             m_ov;

    modport master (
        output s_valid, s_a, s_b, s_bi, m_ready,
        input  s_ready, m_valid, m_d, m_bo, m_ov
    );

    modport slave (
        input  s_valid, s_a, s_b, s_bi, m_ready,
        output s_ready, m_valid, m_d, m_bo, m_ov
    );
endinterface

// File: rtl/subtractor_hcs_pipe.sv
// subtractor_hcs_pipe: pipelined Han-Carlson prefix subtractor d = a - b - bi with valid/ready streaming
module subtractor_hcs_pipe #(
    parameter int WIDTH = 16
) (
    input logic                  clk,
    input logic                  rst,
    subtractor_hcs_pipe_if.slave sub_if
);
    localparam int L = $clog2(WIDTH);
    localparam int N = L + 2;

    logic [WIDTH-1:0] nb;
    logic [WIDTH-1:0] g_d [L+1];
    logic [WIDTH-1:0] p_d [L+1];
    logic [WIDTH+2:0] x_d [L+1];
    logic [WIDTH-1:0] g_q [L+1];
    logic [WIDTH-1:0] p_q [L+1];
    logic [WIDTH+2:0] x_q [L+1];
    logic [N-1:0]     vld_q;
    logic [N-1:0]     vin;
    logic [N-1:0]     ld;
    logic [WIDTH-1:0] gf;
    logic [WIDTH-1:0] d_d;
    logic [WIDTH-1:0] d_q;
    logic             bo_d;
    logic             bo_q;
    logic             ov_d;
    logic             ov_q;

    assign nb = ~sub_if.s_b;
    assign g_d[0] = {sub_if.s_a[WIDTH-1:1] & nb[WIDTH-1:1],
                     (sub_if.s_a[0] & nb[0]) | ((sub_if.s_a[0] ^ nb[0]) & ~sub_if.s_bi)};
    assign p_d[0] = sub_if.s_a ^ nb;
    assign x_d[0] = {sub_if.s_a[WIDTH-1], sub_if.s_b[WIDTH-1], ~sub_if.s_bi, sub_if.s_a ^ nb};

    for (genvar k = 1; k <= L; k++) begin : g_lvl
        assign x_d[k] = x_q[k-1];
        for (genvar i = 0; i < WIDTH; i++) begin : g_bit
            if (i % 2 == 1 && i >= (1 << (k - 1))) begin : g_op
                assign g_d[k][i] = g_q[k-1][i] | (p_q[k-1][i] & g_q[k-1][i-(1<<(k-1))]);
                assign p_d[k][i] = p_q[k-1][i] & p_q[k-1][i-(1<<(k-1))];
            end else begin : g_pass
                assign g_d[k][i] = g_q[k-1][i];
                assign p_d[k][i] = p_q[k-1][i];
            end
        end
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_fix
        if (i % 2 == 1 || i == 0) begin : g_odd
            assign gf[i] = g_q[L][i];
        end else begin : g_even
            assign gf[i] = g_q[L][i] | (p_q[L][i] & g_q[L][i-1]);
        end
    end

    assign d_d  = x_q[L][WIDTH-1:0] ^ {gf[WIDTH-2:0], x_q[L][WIDTH]};
    assign bo_d = ~gf[WIDTH-1];
    assign ov_d = (x_q[L][WIDTH+2] ^ x_q[L][WIDTH+1]) & (d_d[WIDTH-1] ^ x_q[L][WIDTH+2]);

    for (genvar k = 0; k < N; k++) begin : g_ld
        assign ld[k] = sub_if.m_ready | ~&vld_q[N-1:k];
    end

    assign vin            = {vld_q[N-2:0], sub_if.s_valid};
    assign sub_if.s_ready = ld[0];
    assign sub_if.m_valid = vld_q[N-1];
    assign sub_if.m_d     = d_q;
    assign sub_if.m_bo    = bo_q;
    assign sub_if.m_ov    = ov_q;

    // stage valids: each loading stage takes its upstream valid, so bubbles collapse
    always_ff @(posedge clk) begin
        if (rst) vld_q <= '0;
        else vld_q <= (vld_q & ~ld) | (vin & ld);
    end

    for (genvar k = 0; k <= L; k++) begin : g_stg
        // prefix stage data, captured only when real data enters so idle stages keep their contents
        always_ff @(posedge clk) begin
            if (rst) begin
                g_q[k] <= '0;
                p_q[k] <= '0;
                x_q[k] <= '0;
            end else if (ld[k] & vin[k]) begin
                g_q[k] <= g_d[k];
                p_q[k] <= p_d[k];
                x_q[k] <= x_d[k];
            end
        end
    end

    // output stage: even-bit fix-up result, held stable while stalled
    always_ff @(posedge clk) begin
        if (rst) begin
            d_q  <= '0;
            bo_q <= 1'b0;
            ov_q <= 1'b0;
        end else if (ld[N-1] & vin[N-1]) begin
            d_q  <= d_d;
            bo_q <= bo_d;
            ov_q <= ov_d;
        end
    end
endmodule

// File: tb/tb_subtractor_hcs_pipe.sv
// tb_subtractor_hcs_pipe: directed and streaming checks of the pipelined subtractor against an arithmetic model
module tb_subtractor_hcs_pipe;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   asserts = 0;
    int   fails = 0;
    int   cyc = 0;
    int   popped = 0;
    int   seen_cyc = 0;

    typedef struct packed {
        logic        ov;
        logic        bo;
        logic [15:0] d;
    } res_t;

    res_t exp_q[$];
    logic hold = 1'b0;
    res_t held;

    subtractor_hcs_pipe_if #(.WIDTH(16)) bus();
    subtractor_hcs_pipe #(.WIDTH(16)) dut (.clk(clk), .rst(rst), .sub_if(bus));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic res_t model(input logic [15:0] a, input logic [15:0] b, input logic bi);
        logic [16:0] u;
        int          s;
        res_t        r;
        u    = {1'b0, a} - {1'b0, b} - {16'd0, bi};
        s    = int'($signed(a)) - int'($signed(b)) - int'(bi);
        r.d  = u[15:0];
        r.bo = u[16];
        r.ov = (s > 32767) || (s < -32768);
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        asserts++;
        if (act !== want) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, want);
        end
    endtask

    // scoreboard: push on accept, pop and compare on drain, check stability while stalled
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            hold = 1'b0;
        end else begin
            if (hold) begin
                chk("hold_valid", 32'(bus.m_valid), 1);
                chk("hold_data", 32'({bus.m_ov, bus.m_bo, bus.m_d}), 32'(held));
            end
            if (bus.m_valid && bus.m_ready) begin
                chk("out_pending", 32'(exp_q.size() > 0), 1);
                if (exp_q.size() > 0) begin
                    chk("result", 32'({bus.m_ov, bus.m_bo, bus.m_d}), 32'(exp_q.pop_front()));
                    popped++;
                end
            end
            hold = bus.m_valid && !bus.m_ready;
            held = {bus.m_ov, bus.m_bo, bus.m_d};
            if (bus.s_valid && bus.s_ready) exp_q.push_back(model(bus.s_a, bus.s_b, bus.s_bi));
        end
    end

    task automatic send(input logic [15:0] a, input logic [15:0] b, input logic bi);
        bit ok = 1'b0;
        bus.s_valid = 1'b1;
        bus.s_a     = a;
        bus.s_b     = b;
        bus.s_bi    = bi;
        for (int t = 0; t < 50 && !ok; t++) begin
            @(negedge clk);
            ok = bus.s_ready;
            @(posedge clk);
            #1;
        end
        chk("send_accept", 32'(ok), 1);
    endtask

    task automatic expect_out(input string nm, input logic [15:0] d, input logic bo, input logic ov);
        int t = 0;
        while (!bus.m_valid && t < 50) begin
            @(posedge clk);
            #1;
            t++;
        end
        seen_cyc = cyc;
        chk({nm, "_valid"}, 32'(bus.m_valid), 1);
        chk({nm, "_d"}, 32'(bus.m_d), 32'(d));
        chk({nm, "_bo"}, 32'(bus.m_bo), 32'(bo));
        chk({nm, "_ov"}, 32'(bus.m_ov), 32'(ov));
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0;
        int p0;
        int acc;
        bus.s_valid = 1'b0;
        bus.s_a     = '0;
        bus.s_b     = '0;
        bus.s_bi    = 1'b0;
        bus.m_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_m_valid", 32'(bus.m_valid), 0);
        chk("rst_m_d", 32'(bus.m_d), 0);
        chk("rst_m_bo", 32'(bus.m_bo), 0);
        chk("rst_m_ov", 32'(bus.m_ov), 0);
        chk("rst_s_ready", 32'(bus.s_ready), 1);

        t0 = cyc;
        send(16'h0005, 16'h0003, 1'b0);
        bus.s_valid = 1'b0;
        expect_out("t1", 16'h0002, 1'b0, 1'b0);
        chk("t1_latency", 32'(seen_cyc - t0), 6);

        send(16'h0000, 16'h0001, 1'b0);
        bus.s_valid = 1'b0;
        expect_out("t2a", 16'hFFFF, 1'b1, 1'b0);
        send(16'h0005, 16'h0005, 1'b1);
        bus.s_valid = 1'b0;
        expect_out("t2b", 16'hFFFF, 1'b1, 1'b0);

        send(16'h8000, 16'h0001, 1'b0);
        bus.s_valid = 1'b0;
        expect_out("t3a", 16'h7FFF, 1'b0, 1'b1);
        send(16'h7FFF, 16'hFFFF, 1'b0);
        bus.s_valid = 1'b0;
        expect_out("t3b", 16'h8000, 1'b1, 1'b1);

        t0 = cyc;
        p0 = popped;
        for (int i = 0; i < 200; i++) send(16'($urandom), 16'($urandom), 1'($urandom));
        chk("t4_cycles", 32'(cyc - t0), 200);
        bus.s_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        chk("t4_drained", 32'(exp_q.size()), 0);
        chk("t4_count", 32'(popped - p0), 200);

        bus.m_ready = 1'b0;
        bus.s_valid = 1'b1;
        bus.s_a     = 16'($urandom);
        bus.s_b     = 16'($urandom);
        bus.s_bi    = 1'($urandom);
        acc = 0;
        p0  = popped;
        for (int i = 0; i < 12; i++) begin
            bit ok;
            @(negedge clk);
            ok = bus.s_ready;
            if (ok) acc++;
            @(posedge clk);
            #1;
            if (ok) begin
                bus.s_a  = 16'($urandom);
                bus.s_b  = 16'($urandom);
                bus.s_bi = 1'($urandom);
            end
        end
        chk("t5_accepted", 32'(acc), 6);
        chk("t5_s_ready", 32'(bus.s_ready), 0);
        chk("t5_inflight", 32'(exp_q.size()), 6);
        chk("t5_m_valid", 32'(bus.m_valid), 1);
        bus.s_valid = 1'b0;
        bus.m_ready = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        chk("t5_drained", 32'(exp_q.size()), 0);
        chk("t5_count", 32'(popped - p0), 6);

        for (int i = 0; i < 4; i++) send(16'hF000 + 16'(i), 16'h0100, 1'b0);
        bus.s_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("t6_m_valid", 32'(bus.m_valid), 0);
        chk("t6_m_d", 32'(bus.m_d), 0);
        chk("t6_m_bo", 32'(bus.m_bo), 0);
        chk("t6_m_ov", 32'(bus.m_ov), 0);
        chk("t6_s_ready", 32'(bus.s_ready), 1);
        p0 = popped;
        repeat (12) @(posedge clk);
        #1;
        chk("t6_no_stale", 32'(popped - p0), 0);
        chk("t6_m_valid_idle", 32'(bus.m_valid), 0);
        send(16'h1234, 16'h0234, 1'b0);
        bus.s_valid = 1'b0;
        expect_out("t6_after", 16'h1000, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
        $finish;
    end
endmodule
